// File: rtl/sync_sp_ram_arb_2x64.sv
// -----------------------------------------------------------------------------
// sync_sp_ram_arb_2x64
//
// Round-robin arbiter and sequencer for two requesters that share one
// single-port N x 64 byte-enabled synchronous RAM (sync_sp_ram_be_nx64).
// At most one request is granted per cycle, in the same cycle it is presented.
// The granted request is forwarded to the RAM port. Read data is tagged with
// the requester id and returned LAT = 1 + OUT_REGS cycles after the grant.
//
// Optional feature (macro SP_RAM_ARB_INIT_EN):
//   defined   - after reset an INIT phase writes zero to every word
//               0..DATA_DEPTH-1 (one word per cycle) before the first grant.
//   undefined - no init counter is built; the block is ready immediately.
//
// Ports:
//   Clk_CI          clock
//   Rst_RI          synchronous active-high reset
//   Req_SI[1:0]     request per requester
//   Gnt_SO[1:0]     grant, one-hot or zero (accept = Req & Gnt)
//   WrEn_SI[1:0]    1 = write, 0 = read, per requester
//   BEn_SI          byte enables per requester (2 x 8)
//   WrData_DI       write data per requester (2 x 64)
//   Addr_DI         word address per requester (2 x ADDR_WIDTH)
//   RdValid_SO[1:0] read data valid for the originating requester
//   RdData_DO       shared read data, qualified by RdValid_SO
//   Ready_SO        high while in RUN
//   Ram_*           RAM port (CSel, WrEn, BEn, WrData, Addr, RdData)
// -----------------------------------------------------------------------------
module sync_sp_ram_arb_2x64 #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned OUT_REGS   = 0
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RI,
  input  logic [1:0]                 Req_SI,
  output logic [1:0]                 Gnt_SO,
  input  logic [1:0]                 WrEn_SI,
  input  logic [1:0][7:0]            BEn_SI,
  input  logic [1:0][63:0]           WrData_DI,
  input  logic [1:0][ADDR_WIDTH-1:0] Addr_DI,
  output logic [1:0]                 RdValid_SO,
  output logic [63:0]                RdData_DO,
  output logic                       Ready_SO,
  output logic                       Ram_CSel_SO,
  output logic                       Ram_WrEn_SO,
  output logic [7:0]                 Ram_BEn_SO,
  output logic [63:0]                Ram_WrData_DO,
  output logic [ADDR_WIDTH-1:0]      Ram_Addr_DO,
  input  logic [63:0]                Ram_RdData_DI
);

  localparam int unsigned LAT = 1 + OUT_REGS;

  logic                  run;          // arbiter may grant this cycle
  logic                  init_active;  // zero-fill owns the RAM port this cycle
  logic [ADDR_WIDTH-1:0] init_addr;

  // ---------------------------------------------------------------------------
  // Sequencer: INIT (zero fill) -> RUN, or straight to RUN without the feature.
  // Everything is gated with Rst_RI so outputs are quiet during reset even
  // though reset is only sampled at the clock edge.
  // ---------------------------------------------------------------------------
`ifdef SP_RAM_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;

  // NOTE: state is written with non-blocking assignments only, so every
  // always_ff sees the pre-edge value of every register regardless of
  // evaluation order.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q == ADDR_WIDTH'(DATA_DEPTH - 1)) begin
            state_q <= ST_RUN;
          end else begin
            init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
          end
        end
        default: state_q <= ST_RUN;  // RUN is terminal until reset
      endcase
    end
  end

  assign init_active = (state_q == ST_INIT) && !Rst_RI;
  assign run         = (state_q == ST_RUN)  && !Rst_RI;
  assign init_addr   = init_cnt_q;
`else
  assign init_active = 1'b0;
  assign run         = !Rst_RI;
  assign init_addr   = '0;
`endif

  assign Ready_SO = run;

  // ---------------------------------------------------------------------------
  // Round-robin grant. last_gnt_q holds the index granted most recently; on a
  // conflict the other requester wins. Reset value 1 lets requester 0 win the
  // first conflict.
  // ---------------------------------------------------------------------------
  logic       last_gnt_q, last_gnt_d;
  logic [1:0] req_run;
  logic       gnt_id;
  logic       any_gnt;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    req_run = Req_SI & {2{run}};
    Gnt_SO  = 2'b00;
    case (req_run)
      2'b01:   Gnt_SO = 2'b01;
      2'b10:   Gnt_SO = 2'b10;
      2'b11:   Gnt_SO = last_gnt_q ? 2'b01 : 2'b10;
      default: Gnt_SO = 2'b00;
    endcase
  end

  assign gnt_id     = Gnt_SO[1];
  assign any_gnt    = |Gnt_SO;
  assign last_gnt_d = any_gnt ? gnt_id : last_gnt_q;

  // ---------------------------------------------------------------------------
  // RAM port mux: zero-fill during INIT, otherwise the granted requester.
  // WrData/Addr follow requester gnt_id even without a grant (don't-care then),
  // which keeps the mux free of an extra select term.
  // ---------------------------------------------------------------------------
  always_comb begin
    Ram_CSel_SO   = 1'b0;
    Ram_WrEn_SO   = 1'b0;
    Ram_BEn_SO    = 8'h00;
    Ram_WrData_DO = WrData_DI[gnt_id];
    Ram_Addr_DO   = Addr_DI[gnt_id];
    if (init_active) begin
      Ram_CSel_SO   = 1'b1;
      Ram_WrEn_SO   = 1'b1;
      Ram_BEn_SO    = 8'hFF;
      Ram_WrData_DO = '0;
      Ram_Addr_DO   = init_addr;
    end else if (any_gnt) begin
      Ram_CSel_SO = 1'b1;
      Ram_WrEn_SO = WrEn_SI[gnt_id];
      Ram_BEn_SO  = BEn_SI[gnt_id];
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline: LAT stages of {valid, id}, matching the RAM read
  // latency, so the tag leaves the last stage together with its data.
  // Reset clears the valids, dropping any read still in flight.
  // ---------------------------------------------------------------------------
  logic [LAT-1:0] rsp_vld_q;
  logic [LAT-1:0] rsp_id_q;
  logic           rsp_vld_d;
  logic           rsp_id_d;

  assign rsp_vld_d = any_gnt && !WrEn_SI[gnt_id];
  assign rsp_id_d  = gnt_id;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      rsp_vld_q  <= '0;
      rsp_id_q   <= '0;
      last_gnt_q <= 1'b1;
    end else begin
      rsp_vld_q[0] <= rsp_vld_d;
      rsp_id_q[0]  <= rsp_id_d;
      for (int i = 1; i < int'(LAT); i++) begin
        rsp_vld_q[i] <= rsp_vld_q[i-1];
        rsp_id_q[i]  <= rsp_id_q[i-1];
      end
      last_gnt_q <= last_gnt_d;
    end
  end

  assign RdValid_SO = {2{rsp_vld_q[LAT-1] && !Rst_RI}}
                    & {rsp_id_q[LAT-1], !rsp_id_q[LAT-1]};
  assign RdData_DO  = Ram_RdData_DI;

  // ---------------------------------------------------------------------------
  // Simulation checks
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge Clk_CI) disable iff (Rst_RI)
    Gnt_SO != 2'b11);
  a_gnt_has_req : assert property (@(posedge Clk_CI) disable iff (Rst_RI)
    (Gnt_SO & ~Req_SI) == 2'b00);
  a_addr_range : assert property (@(posedge Clk_CI) disable iff (Rst_RI)
    any_gnt |-> (32'(Addr_DI[gnt_id]) < DATA_DEPTH));
`endif

endmodule

// File: tb/tb_sync_sp_ram_arb_2x64.sv
// -----------------------------------------------------------------------------
// Testbench for sync_sp_ram_arb_2x64 (DATA_DEPTH = 16, OUT_REGS = 1).
// A behavioural single-port byte-enabled RAM sits on the RAM port. A monitor
// predicts grants, RAM port contents and read responses from the driven
// stimulus; read expectations go into a scoreboard queue and are compared when
// RdValid_SO is due. Scenario tasks add their own directed comparisons.
// The INIT expectations follow SP_RAM_ARB_INIT_EN.
// -----------------------------------------------------------------------------
module tb_sync_sp_ram_arb_2x64;

  localparam int AW       = 5;
  localparam int DEPTH    = 16;
  localparam int OUT_REGS = 1;
  localparam int L        = 1 + OUT_REGS;
`ifdef SP_RAM_ARB_INIT_EN
  localparam int INIT_CYC = DEPTH;
`else
  localparam int INIT_CYC = 0;
`endif

  typedef struct {
    int          due;
    logic        id;
    logic [63:0] data;
  } rsp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          req = 2'b00;
  logic [1:0]          we_v = 2'b00;
  logic [1:0][7:0]     ben_v = '0;
  logic [1:0][63:0]    wd_v = '0;
  logic [1:0][AW-1:0]  addr_v = '0;

  logic [1:0]          gnt;
  logic [1:0]          rd_valid;
  logic [63:0]         rd_data;
  logic                ready;
  logic                ram_csel;
  logic                ram_wren;
  logic [7:0]          ram_ben;
  logic [63:0]         ram_wdata;
  logic [AW-1:0]       ram_addr;
  logic [63:0]         ram_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model state
  logic [63:0] ref_mem [0:31];
  logic        m_last = 1'b1;
  int          m_left = INIT_CYC;
  rsp_t        sb_q[$];

  always #5 clk = ~clk;

  sync_sp_ram_arb_2x64 #(
    .ADDR_WIDTH (AW),
    .DATA_DEPTH (DEPTH),
    .OUT_REGS   (OUT_REGS)
  ) dut (
    .Clk_CI        (clk),
    .Rst_RI        (rst),
    .Req_SI        (req),
    .Gnt_SO        (gnt),
    .WrEn_SI       (we_v),
    .BEn_SI        (ben_v),
    .WrData_DI     (wd_v),
    .Addr_DI       (addr_v),
    .RdValid_SO    (rd_valid),
    .RdData_DO     (rd_data),
    .Ready_SO      (ready),
    .Ram_CSel_SO   (ram_csel),
    .Ram_WrEn_SO   (ram_wren),
    .Ram_BEn_SO    (ram_ben),
    .Ram_WrData_DO (ram_wdata),
    .Ram_Addr_DO   (ram_addr),
    .Ram_RdData_DI (ram_rdata)
  );

  function automatic logic [63:0] merge(input logic [63:0] old_d,
                                        input logic [63:0] new_d,
                                        input logic [7:0]  ben);
    logic [63:0] r;
    r = old_d;
    for (int b = 0; b < 8; b++) if (ben[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
    return r;
  endfunction

  // Behavioural RAM, read latency 1 + OUT_REGS
  logic [63:0] ram_mem [0:31];
  logic [63:0] ram_rd0 = '0;
  logic [63:0] ram_rd1 = '0;

  always @(posedge clk) begin
    if (ram_csel) begin
      if (ram_wren) ram_mem[ram_addr] <= merge(ram_mem[ram_addr], ram_wdata, ram_ben);
      else          ram_rd0 <= ram_mem[ram_addr];
    end
    ram_rd1 <= ram_rd0;
  end
  assign ram_rdata = ram_rd1;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard, sampled on the falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    logic [1:0]    eg;
    logic          er;
    logic          gid;
    logic [1:0]    ev;
    logic [AW-1:0] ea;
    rsp_t          e;
    if (rst) begin
      checks++;
      if ({gnt, rd_valid, ready, ram_csel, ram_wren, ram_ben} !== 15'b0) begin
        failures++;
        $display("FAIL reset_outputs: got %h expected 0",
                 {gnt, rd_valid, ready, ram_csel, ram_wren, ram_ben});
      end
      m_last = 1'b1;
      m_left = INIT_CYC;
      sb_q.delete();
    end else begin
      er = (m_left == 0);
      eg = 2'b00;
      if (er) begin
        case (req)
          2'b01:   eg = 2'b01;
          2'b10:   eg = 2'b10;
          2'b11:   eg = m_last ? 2'b01 : 2'b10;
          default: eg = 2'b00;
        endcase
      end
      checks++;
      if (ready !== er) begin
        failures++;
        $display("FAIL ready @%0d: got %b expected %b", cyc, ready, er);
      end
      checks++;
      if (gnt !== eg) begin
        failures++;
        $display("FAIL grant @%0d: got %b expected %b", cyc, gnt, eg);
      end
      if (!er) begin
        ea = AW'(INIT_CYC - m_left);
        checks++;
        if ({ram_csel, ram_wren, ram_ben, ram_wdata, ram_addr} !== {1'b1, 1'b1, 8'hFF, 64'h0, ea}) begin
          failures++;
          $display("FAIL init_port @%0d: got cs=%b we=%b be=%h wd=%h a=%0d expected 1 1 ff 0 %0d",
                   cyc, ram_csel, ram_wren, ram_ben, ram_wdata, ram_addr, ea);
        end
        ref_mem[ea] = 64'h0;
        m_left--;
      end else if (eg != 2'b00) begin
        gid = eg[1];
        ea  = addr_v[gid];
        checks++;
        if ({ram_csel, ram_wren, ram_ben, ram_addr} !==
            {1'b1, we_v[gid], (we_v[gid] ? ben_v[gid] : ram_ben), ea}) begin
          failures++;
          $display("FAIL ram_port @%0d: got cs=%b we=%b be=%h a=%0d expected 1 %b %h %0d",
                   cyc, ram_csel, ram_wren, ram_ben, ram_addr, we_v[gid], ben_v[gid], ea);
        end
        if (we_v[gid]) begin
          checks++;
          if (ram_wdata !== wd_v[gid]) begin
            failures++;
            $display("FAIL ram_wdata @%0d: got %h expected %h", cyc, ram_wdata, wd_v[gid]);
          end
          ref_mem[ea] = merge(ref_mem[ea], wd_v[gid], ben_v[gid]);
        end else begin
          sb_q.push_back('{due: cyc + L, id: gid, data: ref_mem[ea]});
        end
        m_last = gid;
      end else begin
        checks++;
        if ({ram_csel, ram_wren, ram_ben} !== 10'b0) begin
          failures++;
          $display("FAIL idle_port @%0d: got cs=%b we=%b be=%h expected 0 0 00",
                   cyc, ram_csel, ram_wren, ram_ben);
        end
      end
      ev = 2'b00;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e  = sb_q.pop_front();
        ev = e.id ? 2'b10 : 2'b01;
      end
      checks++;
      if (rd_valid !== ev) begin
        failures++;
        $display("FAIL rd_valid @%0d: got %b expected %b", cyc, rd_valid, ev);
      end
      if (ev != 2'b00) begin
        checks++;
        if (rd_data !== e.data) begin
          failures++;
          $display("FAIL rd_data @%0d: got %h expected %h", cyc, rd_data, e.data);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic issue(input int m, input logic w, input logic [7:0] b,
                       input logic [63:0] d, input logic [AW-1:0] a, output int gcyc);
    bit got;
    @(posedge clk); #1;
    we_v[m] = w; ben_v[m] = b; wd_v[m] = d; addr_v[m] = a; req[m] = 1'b1;
    got  = 1'b0;
    gcyc = -1;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (gnt[m]) begin
        got  = 1'b1;
        gcyc = cyc;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL grant_timeout req%0d: got no grant expected grant within 20 cycles", m);
    end
    @(posedge clk); #1;
    req[m] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 20 && sb_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending reads expected 0", sb_q.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    req = 2'b11; we_v = 2'b00; addr_v[0] = AW'(5); addr_v[1] = AW'(6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({ready, gnt} !== 3'b000) begin
        failures++;
        $display("FAIL in_reset: got ready=%b gnt=%b expected 0 00", ready, gnt);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < INIT_CYC; i++) begin
      @(negedge clk);
      checks++;
      if ({ram_addr, ram_ben, ram_wdata, gnt, ready} !== {AW'(i), 8'hFF, 64'h0, 2'b00, 1'b0}) begin
        failures++;
        $display("FAIL init_step %0d: got a=%0d be=%h wd=%h gnt=%b rdy=%b expected %0d ff 0 00 0",
                 i, ram_addr, ram_ben, ram_wdata, gnt, ready, i);
      end
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if ({ready, gnt} !== {1'b1, exp_g}) begin
        failures++;
        $display("FAIL alternate %0d: got rdy=%b gnt=%b expected 1 %b", k, ready, gnt, exp_g);
      end
    end
    @(posedge clk); #1;
    req = 2'b00;
  endtask

  task automatic test_write_merge();
    int g;
    issue(0, 1'b1, 8'hFF, 64'h1122334455667788, AW'(3), g);
    issue(0, 1'b1, 8'h0F, 64'hAA00BB00CC00DD00, AW'(3), g);
    issue(0, 1'b0, 8'h00, 64'h0, AW'(3), g);
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      if (k < L) begin
        checks++;
        if (rd_valid !== 2'b00) begin
          failures++;
          $display("FAIL merge_early: got %b expected 00", rd_valid);
        end
      end else begin
        checks++;
        if ({rd_valid, rd_data} !== {2'b01, 64'h11223344CC00DD00}) begin
          failures++;
          $display("FAIL merge_read: got %b %h expected 01 11223344cc00dd00", rd_valid, rd_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int          g;
    logic [63:0] d_tab [3];
    logic [1:0]  eg, ev;
    d_tab[0] = 64'h0123456789ABCDEF;
    d_tab[1] = 64'hFEDCBA9876543210;
    d_tab[2] = 64'h5A5A5A5AA5A5A5A5;
    for (int i = 0; i < 3; i++) issue(0, 1'b1, 8'hFF, d_tab[i], AW'(i), g);
    we_v[1] = 1'b0; addr_v[1] = AW'(0); req[1] = 1'b1;
    for (int j = 0; j < L + 3; j++) begin
      @(negedge clk);
      eg = (j < 3) ? 2'b10 : 2'b00;
      ev = (j >= L && j < L + 3) ? 2'b10 : 2'b00;
      checks++;
      if ({gnt, rd_valid} !== {eg, ev}) begin
        failures++;
        $display("FAIL b2b %0d: got gnt=%b vld=%b expected %b %b", j, gnt, rd_valid, eg, ev);
      end
      if (j >= L && j < L + 3) begin
        checks++;
        if (rd_data !== d_tab[j-L]) begin
          failures++;
          $display("FAIL b2b_data %0d: got %h expected %h", j - L, rd_data, d_tab[j-L]);
        end
      end
      @(posedge clk); #1;
      if (j + 1 < 3) addr_v[1] = AW'(j + 1);
      else           req[1] = 1'b0;
    end
  endtask

  task automatic test_read_after_write();
    bit got;
    @(posedge clk); #1;
    we_v[0] = 1'b1; ben_v[0] = 8'hFF; wd_v[0] = 64'hC0FFEE00BADC0DE5; addr_v[0] = AW'(9);
    req[0] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = gnt[0];
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL raw_wr_grant: got no grant expected grant");
    end
    @(posedge clk); #1;
    we_v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01) begin
      failures++;
      $display("FAIL raw_rd_grant: got %b expected 01", gnt);
    end
    @(posedge clk); #1;
    req[0] = 1'b0;
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      if (k == L) begin
        checks++;
        if ({rd_valid, rd_data} !== {2'b01, 64'hC0FFEE00BADC0DE5}) begin
          failures++;
          $display("FAIL raw_read: got %b %h expected 01 c0ffee00badc0de5", rd_valid, rd_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid_init();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < INIT_CYC; i++) begin
      @(negedge clk);
      checks++;
      if (ram_addr !== AW'(i)) begin
        failures++;
        $display("FAIL pre_abort_addr: got %0d expected %0d", ram_addr, i);
      end
      if (i == 7) break;
    end
    if (INIT_CYC > 0) begin
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
    end
    for (int i = 0; i < INIT_CYC; i++) begin
      @(negedge clk);
      checks++;
      if ({ram_csel, ram_addr, ready} !== {1'b1, AW'(i), 1'b0}) begin
        failures++;
        $display("FAIL restart_init %0d: got cs=%b a=%0d rdy=%b expected 1 %0d 0",
                 i, ram_csel, ram_addr, ready, i);
      end
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_init: got %b expected 1", ready);
    end
  endtask

  task automatic test_reset_mid_read();
    int g;
    bit up;
    @(posedge clk); #1;
    we_v[1] = 1'b0; addr_v[1] = AW'(1); req[1] = 1'b1;
    g = -1;
    for (int t = 0; t < 20 && g < 0; t++) begin
      @(negedge clk);
      if (gnt[1]) g = cyc;
    end
    checks++;
    if (g < 0) begin
      failures++;
      $display("FAIL abort_grant: got no grant expected grant");
    end
    @(posedge clk); #1; req[1] = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (rd_valid !== 2'b00) begin
        failures++;
        $display("FAIL dropped_read %0d: got %b expected 00", k, rd_valid);
      end
    end
    up = 1'b0;
    for (int t = 0; t < INIT_CYC + 4 && !up; t++) begin
      @(negedge clk);
      up = ready;
    end
    checks++;
    if (!up) begin
      failures++;
      $display("FAIL ready_after_abort: got 0 expected 1");
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram_mem[i] = {32'hDEAD0000, 32'(i)};
      ref_mem[i] = {32'hDEAD0000, 32'(i)};
    end
    test_reset();
    test_alternate();
    wait_drain();
    test_write_merge();
    test_back_to_back();
    test_read_after_write();
    test_reset_mid_init();
    test_reset_mid_read();
    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sync_sp_ram_arb_2x64.md
Name: sync_sp_ram_arb_2x64

Overview:
Two-requester round-robin arbiter and sequencer in front of one sync_sp_ram_be_nx64 instance (N x 64 bit, byte enables, single port). It grants at most one request per cycle, drives the RAM port, and returns read data to the originating requester after the fixed RAM latency. An optional zero-fill FSM clears the whole RAM after reset, before the first grant.

Parameters:
ADDR_WIDTH, 10, RAM address width; must match the RAM instance.
DATA_DEPTH, 1024, number of RAM words; must satisfy DATA_DEPTH <= 2**ADDR_WIDTH.
OUT_REGS, 0, must match the RAM's OUT_REGS; read latency L = 1 + OUT_REGS cycles.

Ports:
Clk_CI  in  1  clock.
Rst_RI  in  1  reset; synchronous to Clk_CI, active-high.
Req_SI  in  2  request, one bit per requester m.
Gnt_SO  out  2  grant, one-hot or zero; a request is accepted in the cycle Req_SI[m] & Gnt_SO[m] is high.
WrEn_SI  in  2  1 = write, 0 = read, per requester.
BEn_SI  in  2x8  byte enables per requester.
WrData_DI  in  2x64  write data per requester.
Addr_DI  in  2xADDR_WIDTH  word address per requester.
RdValid_SO  out  2  read data valid for requester m.
RdData_DO  out  64  read data, shared; qualified by RdValid_SO.
Ready_SO  out  1  high once the arbiter is in RUN.
Ram_CSel_SO  out  1  to RAM CSel_SI.
Ram_WrEn_SO  out  1  to RAM WrEn_SI.
Ram_BEn_SO  out  8  to RAM BEn_SI.
Ram_WrData_DO  out  64  to RAM WrData_DI.
Ram_Addr_DO  out  ADDR_WIDTH  to RAM Addr_DI.
Ram_RdData_DI  in  64  from RAM RdData_DO.

Behaviour:
- Reset: the FSM enters INIT (feature enabled) or RUN (feature disabled). Priority pointer LastGnt = 1, so requester 0 wins the first conflict. Response pipeline is cleared; init counter = 0.
- While Rst_RI = 1: Gnt_SO = 0, RdValid_SO = 0, Ready_SO = 0, Ram_CSel_SO = 0, Ram_WrEn_SO = 0, Ram_BEn_SO = 0.
- RdData_DO = Ram_RdData_DI at all times, with no extra register.
- INIT state:
  - Each cycle drives CSel = 1, WrEn = 1, BEn = 8'hFF, WrData = 0, Addr = counter.
  - The counter increments from 0 to DATA_DEPTH-1. The cycle after the DATA_DEPTH-1 write, the FSM enters RUN.
  - During INIT, Gnt_SO = 0 and Ready_SO = 0. INIT lasts exactly DATA_DEPTH cycles.
  - Reset asserted mid-INIT restarts INIT at address 0.
- RUN state (terminal until reset): Ready_SO = 1.
- Grant logic is combinational, same cycle as the request:
  - Only one requester active: that requester is granted.
  - Both active: grant !LastGnt.
  - Neither active: Gnt_SO = 0 and Ram_CSel_SO = 0.
  - LastGnt is updated to the granted index on every grant.
  - A requester must hold Req and its payload stable until granted.
- RAM port:
  - Ram_CSel_SO = |Gnt_SO.
  - Ram WrEn/BEn/WrData/Addr are muxed from the granted requester.
  - When no grant: WrEn = 0 and BEn = 0; WrData and Addr are don't-care.
- Response pipeline:
  - L-stage shift register of {valid, id}. Stage 0 is loaded with {grant & ~WrEn, granted id}.
  - RdValid_SO[id] = 1 exactly L cycles after a read grant, for one cycle.
  - Writes produce no RdValid.
  - Back-to-back grants (one per cycle) are supported without bubbles.
- Read-during-write: no same-cycle hazard exists (single port). A read granted the cycle after a write to the same address returns the new data.
- Reset mid-read: in-flight responses are dropped, and RdValid_SO never asserts for them.
- Assertions (simulation only):
  - Gnt_SO is never 2'b11.
  - Gnt_SO[m] implies Req_SI[m].
  - Addr of any granted request < DATA_DEPTH.

Optional Feature:
SP_RAM_ARB_INIT_EN
- Defined: the INIT zero-fill FSM and counter are built as described above.
- Undefined: no counter is built; reset goes directly to RUN. Ready_SO = 1 from the first cycle after reset deasserts, and RAM contents are undefined until written.

Test Plan:
1. INIT (SP_RAM_ARB_INIT_EN defined, DATA_DEPTH = 16), release reset with Req_SI = 2'b11:
   - Ram_Addr_DO steps 0..15 with BEn = FF and data 0, Gnt_SO = 0 for 16 cycles.
   - Ready_SO rises in cycle 17.
   - A read of address 5 then returns 64'h0.
2. Both requesters held high for 6 cycles in RUN: Gnt_SO sequence 01,10,01,10,01,10.
3. Requester 0 writes 64'h1122334455667788 to address 3 with BEn = FF, then writes 64'hAA00BB00CC00DD00 to address 3 with BEn = 8'h0F, then reads address 3:
   - RdValid_SO = 01 L cycles after the read grant.
   - RdData_DO = 64'h11223344CC00DD00.
4. OUT_REGS = 1; requester 1 reads addresses 0,1,2 on consecutive grants: RdValid_SO[1] is high for 3 consecutive cycles starting 2 cycles after the first grant, with data in address order.
5. Reset asserted during INIT at address 7, released after 1 cycle: the INIT restarts at address 0 and performs the full DATA_DEPTH writes.
6. Reset asserted 1 cycle after a read grant with OUT_REGS = 1: RdValid_SO stays 0 throughout.
